// File: rtl/pacman_controller.sv
// Pac-Man movement/animation/death controller driven by per-frame ticks.
// Define PACMAN_TURN_BUFFER_EN to keep a blocked turn request pending until it becomes legal.
module pacman_controller #(
  parameter logic [9:0]  X_START      = 10'd320,
  parameter logic [9:0]  Y_START      = 10'd360,
  parameter logic [9:0]  X_MIN        = 10'd7,
  parameter logic [9:0]  X_MAX        = 10'd632,
  parameter logic [9:0]  Y_MAX        = 10'd472,
  parameter int unsigned ANIM_DIV     = 4,
  parameter int unsigned DEATH_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [1:0] dir_req,
  input  logic       dir_req_valid,
  input  logic [3:0] blocked,
  input  logic       kill,
  output logic [9:0] xloc,
  output logic [9:0] yloc,
  output logic [1:0] pacman_dir,
  output logic [1:0] animation_cycle,
  output logic       pacman_alive
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam logic [9:0] Y_MIN = 10'd7;
  localparam logic [1:0] DIR_RT = 2'b00;
  localparam logic [1:0] DIR_UP = 2'b01;
  localparam logic [1:0] DIR_DN = 2'b10;
  localparam logic [1:0] DIR_LT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DYING, S_DEAD} state_t;

  state_t          state, state_nxt;
  logic [9:0]      xloc_nxt, yloc_nxt;
  logic [1:0]      pacman_dir_nxt, animation_cycle_nxt;
  logic            pacman_alive_nxt;
  logic [1:0]      anim_phase, anim_phase_nxt;
  logic [AW-1:0]   anim_cnt, anim_cnt_nxt;
  logic [DW-1:0]   death_cnt, death_cnt_nxt;
  logic            pend_valid, pend_valid_nxt;
  logic [1:0]      pend_dir, pend_dir_nxt;
  logic            req_v_c;
  logic [1:0]      req_dir_c;
  logic [1:0]      dir_new_c;
  logic            moved_c;

  // Next-state, position, turn and animation logic
  always_comb begin
    state_nxt           = state;
    xloc_nxt            = xloc;
    yloc_nxt            = yloc;
    pacman_dir_nxt      = pacman_dir;
    anim_phase_nxt      = anim_phase;
    anim_cnt_nxt        = anim_cnt;
    death_cnt_nxt       = death_cnt;
    pend_valid_nxt      = pend_valid;
    pend_dir_nxt        = pend_dir;
    req_v_c             = pend_valid | dir_req_valid;
    req_dir_c           = dir_req_valid ? dir_req : pend_dir;
    dir_new_c           = pacman_dir;
    moved_c             = 1'b0;

    case (state)
      S_IDLE: begin
        if (frame_tick && start) state_nxt = S_MOVE;
      end
      S_MOVE: begin
        if (dir_req_valid) begin
          pend_valid_nxt = 1'b1;
          pend_dir_nxt   = dir_req;
        end
        if (kill) begin
          state_nxt      = S_DYING;
          pend_valid_nxt = 1'b0;
          death_cnt_nxt  = '0;
        end else if (frame_tick) begin
          // A newly arriving request overrides an older pending one
          if (req_v_c && !blocked[req_dir_c]) begin
            dir_new_c      = req_dir_c;
            pend_valid_nxt = 1'b0;
          end else begin
`ifdef PACMAN_TURN_BUFFER_EN
            pend_valid_nxt = req_v_c;
            pend_dir_nxt   = req_dir_c;
`else
            pend_valid_nxt = 1'b0;
`endif
          end
          pacman_dir_nxt = dir_new_c;
          if (!blocked[dir_new_c]) begin
            case (dir_new_c)
              DIR_RT: xloc_nxt = (xloc >= X_MAX) ? X_MIN : xloc + 10'd1;
              DIR_LT: xloc_nxt = (xloc <= X_MIN) ? X_MAX : xloc - 10'd1;
              DIR_UP: yloc_nxt = (yloc <= Y_MIN) ? Y_MIN : yloc - 10'd1;
              DIR_DN: yloc_nxt = (yloc >= Y_MAX) ? Y_MAX : yloc + 10'd1;
              default: ;
            endcase
          end
          moved_c = (xloc_nxt != xloc) || (yloc_nxt != yloc);
          // Animation divider only runs while actually moving
          if (moved_c) begin
            if (anim_cnt == AW'(ANIM_DIV - 1)) begin
              anim_cnt_nxt   = '0;
              anim_phase_nxt = anim_phase + 2'd1;
            end else begin
              anim_cnt_nxt = anim_cnt + AW'(1);
            end
          end
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          if (death_cnt == DW'(DEATH_FRAMES - 1)) begin
            state_nxt     = S_DEAD;
            death_cnt_nxt = '0;
          end else begin
            death_cnt_nxt = death_cnt + DW'(1);
          end
        end
      end
      S_DEAD: begin
        if (frame_tick && start) begin
          state_nxt      = S_IDLE;
          xloc_nxt       = X_START;
          yloc_nxt       = Y_START;
          pacman_dir_nxt = DIR_RT;
          anim_phase_nxt = '0;
          anim_cnt_nxt   = '0;
          death_cnt_nxt  = '0;
          pend_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Phase sequence 0,1,2,3 maps to frames 0,1,2,1
    animation_cycle_nxt = (anim_phase_nxt == 2'd3) ? 2'd1 : anim_phase_nxt;
    pacman_alive_nxt    = (state_nxt == S_IDLE) || (state_nxt == S_MOVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      xloc            <= X_START;
      yloc            <= Y_START;
      pacman_dir      <= DIR_RT;
      animation_cycle <= 2'd0;
      pacman_alive    <= 1'b1;
      anim_phase      <= '0;
      anim_cnt        <= '0;
      death_cnt       <= '0;
      pend_valid      <= 1'b0;
      pend_dir        <= 2'b00;
    end else begin
      state           <= state_nxt;
      xloc            <= xloc_nxt;
      yloc            <= yloc_nxt;
      pacman_dir      <= pacman_dir_nxt;
      animation_cycle <= animation_cycle_nxt;
      pacman_alive    <= pacman_alive_nxt;
      anim_phase      <= anim_phase_nxt;
      anim_cnt        <= anim_cnt_nxt;
      death_cnt       <= death_cnt_nxt;
      pend_valid      <= pend_valid_nxt;
      pend_dir        <= pend_dir_nxt;
    end
  end

endmodule

// File: tb/tb_pacman_controller.sv
// Scoreboard bench for pacman_controller: expected outputs queued per frame tick, compared one clk later.
module tb_pacman_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       start;
  logic [1:0] dir_req;
  logic       dir_req_valid;
  logic [3:0] blocked;
  logic       kill;
  logic [9:0] xloc, yloc;
  logic [1:0] pacman_dir, animation_cycle;
  logic       pacman_alive;

  pacman_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .dir_req(dir_req), .dir_req_valid(dir_req_valid), .blocked(blocked),
    .kill(kill), .xloc(xloc), .yloc(yloc), .pacman_dir(pacman_dir),
    .animation_cycle(animation_cycle), .pacman_alive(pacman_alive)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] dir;
    logic [1:0] anim;
    logic       alive;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Reference model state
  int   mx, my, mdir, mv;
  logic malive;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int anim_of(input int moves);
    case ((moves / 4) % 4)
      0: return 0;
      1: return 1;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    e.x     = 10'(mx);
    e.y     = 10'(my);
    e.dir   = 2'(mdir);
    e.anim  = 2'(anim_of(mv));
    e.alive = malive;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".x"},     int'(xloc),            int'(e.x));
    check({t, ".y"},     int'(yloc),            int'(e.y));
    check({t, ".dir"},   int'(pacman_dir),      int'(e.dir));
    check({t, ".anim"},  int'(animation_cycle), int'(e.anim));
    check({t, ".alive"}, int'(pacman_alive),    int'(e.alive));
  endtask

  // One frame tick with the given inputs; model must already hold the expected result
  task automatic step(input logic [3:0] blk, input logic st, input logic kl,
                      input logic rv, input logic [1:0] rd, input string tag);
    @(negedge clk);
    blocked = blk; start = st; kill = kl; dir_req_valid = rv; dir_req = rd;
    frame_tick = 1'b1;
    push_exp(tag);
    @(negedge clk);
    frame_tick = 1'b0; start = 1'b0; kill = 1'b0; dir_req_valid = 1'b0;
    pop_cmp();
  endtask

  task automatic req_pulse(input logic [1:0] d);
    @(negedge clk);
    dir_req_valid = 1'b1; dir_req = d;
    @(negedge clk);
    dir_req_valid = 1'b0;
  endtask

  task automatic move_rt(input logic [3:0] blk, input string tag);
    mx++; mv++;
    step(blk, 1'b0, 1'b0, 1'b0, 2'b00, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; dir_req = 2'b00;
    dir_req_valid = 1'b0; blocked = 4'h0; kill = 1'b0;
    mx = 320; my = 360; mdir = 0; mv = 0; malive = 1'b1;
    #12;
    push_exp("reset");
    pop_cmp();
    @(negedge clk) rst_n = 1'b1;

    step(4'h0, 1'b0, 1'b0, 1'b0, 2'b00, "idle_hold");
    step(4'h0, 1'b1, 1'b0, 1'b0, 2'b00, "start");

    for (int k = 0; k < 16; k++) move_rt(4'h0, "anim_run");
    for (int k = 0; k < 3; k++) step(4'hF, 1'b0, 1'b0, 1'b0, 2'b00, "stall");
    // Stall partway through a divider period; count must resume, not restart
    for (int k = 0; k < 2; k++) move_rt(4'h0, "pre_stall");
    for (int k = 0; k < 3; k++) step(4'hF, 1'b0, 1'b0, 1'b0, 2'b00, "mid_stall");
    for (int k = 0; k < 2; k++) move_rt(4'h0, "post_stall");

    req_pulse(2'b01);
    for (int k = 0; k < 3; k++) move_rt(4'b0010, "up_blocked");
`ifdef PACMAN_TURN_BUFFER_EN
    mdir = 1; my--; mv++;
`else
    mx++; mv++;
`endif
    step(4'h0, 1'b0, 1'b0, 1'b0, 2'b00, "turn_buf");

    // Turn requested on the tick itself, then run to the tunnel
    mdir = 3; mx = (mx == 7) ? 632 : mx - 1; mv++;
    step(4'h0, 1'b0, 1'b0, 1'b1, 2'b11, "turn_lt");
    while (mx != 7) begin
      mx--; mv++;
      step(4'h0, 1'b0, 1'b0, 1'b0, 2'b00, "run_lt");
    end
    mx = 632; mv++;
    step(4'h0, 1'b0, 1'b0, 1'b0, 2'b00, "wrap_lt");
    mdir = 0; mx = 7; mv++;
    step(4'h0, 1'b0, 1'b0, 1'b1, 2'b00, "wrap_rt");

    malive = 1'b0;
    step(4'h0, 1'b0, 1'b1, 1'b0, 2'b00, "kill");
    req_pulse(2'b10);
    // start held through all 60 dying ticks must not restart early
    for (int k = 0; k < 60; k++) step(4'h0, 1'b1, 1'b0, 1'b0, 2'b00, "dying");
    mx = 320; my = 360; mdir = 0; mv = 0; malive = 1'b1;
    step(4'h0, 1'b1, 1'b0, 1'b0, 2'b00, "restart");
    step(4'h0, 1'b0, 1'b1, 1'b0, 2'b00, "kill_idle");

    step(4'h0, 1'b1, 1'b0, 1'b0, 2'b00, "start2");
    for (int k = 0; k < 3; k++) move_rt(4'h0, "run2");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    mx = 320; my = 360; mdir = 0; mv = 0; malive = 1'b1;
    push_exp("async_rst");
    pop_cmp();
    @(negedge clk) rst_n = 1'b1;
    step(4'h0, 1'b0, 1'b0, 1'b0, 2'b00, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pacman_controller.md
PACMAN_CONTROLLER -- requirements
Module: pacman_controller

Interface
REQ-001 SHALL have parameter X_START, default 10'd320, reset/restart x centre (pixels).
REQ-002 SHALL have parameter Y_START, default 10'd360, reset/restart y centre (pixels).
REQ-003 SHALL have parameter X_MIN / X_MAX, defaults 10'd7 / 10'd632, tunnel wrap limits for x.
REQ-004 SHALL have parameter Y_MAX, default 10'd472, y saturation limit; y minimum fixed at 7.
REQ-005 SHALL have parameter ANIM_DIV, default 4, frame ticks per animation step (1..15).
REQ-006 SHALL have parameter DEATH_FRAMES, default 60, frame ticks spent in DYING (1..255).
REQ-007 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port frame_tick, input, 1, one-cycle pulse per VGA frame; all motion advances only on it.
REQ-010 SHALL have port start, input, 1, level; leaves IDLE.
REQ-011 SHALL have port dir_req, input, 2, requested direction: 00 RT, 01 UP, 10 DN, 11 LT.
REQ-012 SHALL have port dir_req_valid, input, 1, qualifies dir_req for one cycle.
REQ-013 SHALL have port blocked, input, 4, wall flags {LT,DN,UP,RT} for current tile, from maze logic.
REQ-014 SHALL have port kill, input, 1, one-cycle ghost-collision pulse.
REQ-015 SHALL have ports xloc/yloc, output, 10 each, sprite centre, registered.
REQ-016 SHALL have ports pacman_dir (2), animation_cycle (2), pacman_alive (1), outputs, registered; these drive graphics_pacman directly.

Function
REQ-017 SHALL implement FSM IDLE -> MOVE (start=1 at frame_tick) -> DYING (kill=1) -> DEAD (DEATH_FRAMES ticks elapsed) -> IDLE (start=1 at frame_tick, position reloaded to X_START/Y_START, dir RT).
REQ-018 SHALL, in MOVE on frame_tick, first resolve turn: if a request is pending and blocked[req]=0, pacman_dir<=req and pending cleared; else dir unchanged.
REQ-019 SHALL then, same tick, move 1 pixel in pacman_dir if blocked[pacman_dir_new]=0; otherwise position holds (stalled).
REQ-020 SHALL wrap x: moving LT at X_MIN gives X_MAX; moving RT at X_MAX gives X_MIN; same tick, no intermediate value.
REQ-021 SHALL saturate y at 7 (UP) and Y_MAX (DN) regardless of blocked.
REQ-022 SHALL advance animation_cycle every ANIM_DIV ticks in sequence 0,1,2,1,0,... only while moving; when stalled, hold value and divider count.
REQ-023 SHALL never output animation_cycle=3.
REQ-024 SHALL, in DYING and DEAD, freeze xloc/yloc/pacman_dir/animation_cycle; pacman_alive=0 in DYING and DEAD, 1 otherwise.
REQ-025 SHALL ignore kill outside MOVE; kill has priority over movement on the same frame_tick (no move that tick).
REQ-026 SHALL ignore dir_req_valid outside MOVE and discard any pending request on entry to DYING.
REQ-027 SHALL, when dir_req_valid and frame_tick coincide, use the new request in that tick's turn resolution.
REQ-028 SHALL produce output changes exactly one clk after the frame_tick cycle.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously set state IDLE, xloc=X_START, yloc=Y_START, pacman_dir=00, animation_cycle=0, pacman_alive=1, pending cleared, all counters 0.
REQ-030 SHALL behave identically whether reset asserts mid-move, mid-DYING or in DEAD; first action after release requires start.

Configuration
REQ-031 SHALL, with PACMAN_TURN_BUFFER_EN defined, hold a blocked request pending until it becomes legal or a newer request replaces it.
REQ-032 SHALL, without PACMAN_TURN_BUFFER_EN, keep a request only until the next frame_tick; if blocked then, discard it.

Verification
REQ-033 SHALL verify reset: rst_n=0 mid-move at x=100 -> x=320, y=360, dir=00, anim=0, alive=1 without clk edge.
REQ-034 SHALL verify tunnel: dir=LT, x=7, blocked=0, frame_tick -> x=632 next clk; then RT tick -> x=7.
REQ-035 SHALL verify buffered turn (macro on): req UP while blocked[UP]=1 for 3 ticks, then clear -> dir=01 and y decrements on 4th tick; macro off -> dir stays 00.
REQ-036 SHALL verify animation: ANIM_DIV=4, 16 unblocked ticks -> anim 0,1,2,1,0; blocked=4'hF -> anim and x constant.
REQ-037 SHALL verify death: kill with frame_tick -> no move, alive=0; after 60 ticks state DEAD; start+tick -> x=320, y=360, alive=1.
